// File: rtl/ddr3_dqs_train_pkg.sv
// Shared types and constants for the DDR3 read-DQS eye trainer.
package ddr3_dqs_train_pkg;

  localparam int unsigned TAP_W    = 8;
  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned LOCK_W   = 4;

  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_LOCK_COUNT    = 4;
  localparam int unsigned DEF_MAX_TAPS      = 128;
  localparam int unsigned DEF_MAX_MOVES     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_MOVE,
    ST_DONE,
    ST_ERROR
  } train_state_e;

  // IOD eye-monitor status as seen in the SAMPLE cycle
  typedef struct packed {
    logic early;
    logic late;
    logic out_of_range;
  } eye_flags_t;

endpackage

// File: rtl/ddr3_dqs_train_timer.sv
// Loadable settle down-counter; done_c flags the final settle cycle.
module ddr3_dqs_train_timer
  import ddr3_dqs_train_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done_c
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= SETTLE_W'(CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign done_c = en && (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/ddr3_dqs_eye_trainer.sv
// Per-lane read-DQS eye training controller driving the IOD delay line.
// Define DQS_TRAIN_TRACK_EN to keep tracking the eye after lock.
module ddr3_dqs_eye_trainer
  import ddr3_dqs_train_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned MAX_TAPS      = DEF_MAX_TAPS,
  parameter int unsigned MAX_MOVES     = DEF_MAX_MOVES
) (
  input  logic             fab_clk,
  input  logic             arst_n,
  input  logic             train_start,
  input  logic             train_abort,
  input  logic             eye_monitor_early,
  input  logic             eye_monitor_late,
  input  logic             delay_line_out_of_range,
  output logic             delay_line_load,
  output logic             delay_line_move,
  output logic             delay_line_direction,
  output logic             eye_monitor_clear_flags,
  output logic [TAP_W-1:0] tap_count,
  output logic             train_busy,
  output logic             train_done,
  output logic             train_err
);

  localparam int unsigned MOVE_W = $clog2(MAX_MOVES + 1);
`ifdef DQS_TRAIN_TRACK_EN
  localparam bit TRACK_EN = 1'b1;
`else
  localparam bit TRACK_EN = 1'b0;
`endif

  train_state_e      state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              track_q, track_d;
  logic              load_q, load_d;
  logic              clear_q, clear_d;
  logic              move_q, move_d;
  logic              busy_q, busy_d;
  logic              settle_done_c;
  logic              guard_fail_c;
  eye_flags_t        flags_c;

  assign flags_c = '{early: eye_monitor_early, late: eye_monitor_late,
                     out_of_range: delay_line_out_of_range};

  ddr3_dqs_train_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk    (fab_clk),
    .rst_n  (arst_n),
    .load   (state_q == ST_CLEAR),
    .en     (state_q == ST_SETTLE),
    .done_c (settle_done_c)
  );

  // A requested step is refused here so the MOVE state only ever strobes legal steps
  assign guard_fail_c = (flags_c.early && (tap_q == TAP_W'(MAX_TAPS - 1)))
                     || (!flags_c.early && (tap_q == '0))
                     || flags_c.out_of_range
                     || (!track_q && (moves_q == MOVE_W'(MAX_MOVES)));

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    lock_d  = lock_q;
    moves_d = moves_q;
    dir_d   = dir_q;
    done_d  = done_q;
    err_d   = err_q;
    track_d = track_q;
    if (train_abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
      track_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (train_start) begin
            state_d = ST_LOAD;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        ST_DONE: begin
          if (train_start) begin
            state_d = ST_LOAD;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else if (track_q) begin
            state_d = ST_CLEAR;
          end
        end
        ST_LOAD: begin
          tap_d   = '0;
          lock_d  = '0;
          moves_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          track_d = 1'b0;
          state_d = ST_CLEAR;
        end
        ST_CLEAR: state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (settle_done_c) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (flags_c.early != flags_c.late) begin
            lock_d = '0;
            dir_d  = flags_c.early;
            if (guard_fail_c) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
              done_d  = 1'b0;
              track_d = 1'b0;
            end else begin
              state_d = ST_MOVE;
            end
          end else if (!flags_c.early) begin
            if (track_q) begin
              state_d = ST_CLEAR;
            end else if (lock_q == LOCK_W'(LOCK_COUNT - 1)) begin
              lock_d  = lock_q + LOCK_W'(1);
              done_d  = 1'b1;
              track_d = TRACK_EN;
              state_d = ST_DONE;
            end else begin
              lock_d  = lock_q + LOCK_W'(1);
              state_d = ST_CLEAR;
            end
          end else begin
            lock_d  = '0;
            state_d = ST_CLEAR;
          end
        end
        ST_MOVE: begin
          tap_d = dir_q ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
          if (!track_q) moves_d = moves_q + MOVE_W'(1);
          state_d = ST_CLEAR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they register in step with it
  always_comb begin
    load_d  = 1'b0;
    clear_d = 1'b0;
    move_d  = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      ST_LOAD:  load_d  = 1'b1;
      ST_CLEAR: clear_d = 1'b1;
      ST_MOVE:  move_d  = 1'b1;
      ST_IDLE, ST_DONE, ST_ERROR: busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      tap_q   <= '0;
      lock_q  <= '0;
      moves_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      track_q <= 1'b0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      move_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tap_q   <= tap_d;
      lock_q  <= lock_d;
      moves_q <= moves_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      track_q <= track_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      move_q  <= move_d;
      busy_q  <= busy_d;
    end
  end

  assign delay_line_load         = load_q;
  assign eye_monitor_clear_flags = clear_q;
  assign delay_line_move         = move_q;
  assign delay_line_direction    = dir_q;
  assign tap_count               = tap_q;
  assign train_busy              = busy_q;
  assign train_done              = done_q;
  assign train_err               = err_q;

endmodule

// File: tb/tb_ddr3_dqs_eye_trainer.sv
// Directed bench for ddr3_dqs_eye_trainer: vector table plus corner-case sequences.
module tb_ddr3_dqs_eye_trainer;

  logic       fab_clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       train_start = 1'b0;
  logic       train_abort = 1'b0;
  logic       eye_monitor_early = 1'b0;
  logic       eye_monitor_late = 1'b0;
  logic       delay_line_out_of_range = 1'b0;
  logic       delay_line_load;
  logic       delay_line_move;
  logic       delay_line_direction;
  logic       eye_monitor_clear_flags;
  logic [7:0] tap_count;
  logic       train_busy;
  logic       train_done;
  logic       train_err;

  ddr3_dqs_eye_trainer dut (
    .fab_clk                 (fab_clk),
    .arst_n                  (arst_n),
    .train_start             (train_start),
    .train_abort             (train_abort),
    .eye_monitor_early       (eye_monitor_early),
    .eye_monitor_late        (eye_monitor_late),
    .delay_line_out_of_range (delay_line_out_of_range),
    .delay_line_load         (delay_line_load),
    .delay_line_move         (delay_line_move),
    .delay_line_direction    (delay_line_direction),
    .eye_monitor_clear_flags (eye_monitor_clear_flags),
    .tap_count               (tap_count),
    .train_busy              (train_busy),
    .train_done              (train_done),
    .train_err               (train_err)
  );

  always #5 fab_clk = ~fab_clk;

  typedef struct packed {
    logic       load;
    logic       clear;
    logic       move;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] tap;
  } obs_t;

  typedef struct {
    string name;
    int    ncyc;
    bit    start;
    bit    abort;
    bit    early;
    bit    late;
    bit    oor;
    obs_t  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   moves_seen = 0;
  logic prev_load = 1'b0, prev_clear = 1'b0, prev_move = 1'b0;
  obs_t obs;

  assign obs = {delay_line_load, eye_monitor_clear_flags, delay_line_move, delay_line_direction,
                train_busy, train_done, train_err, tap_count};

  function automatic obs_t mk(bit ld, bit cl, bit mv, bit dr, bit bs, bit dn, bit er, int unsigned tp);
    return obs_t'({ld, cl, mv, dr, bs, dn, er, 8'(tp)});
  endfunction

  function automatic void add(string nm, int n, bit st, bit ab, bit e, bit l, bit o, obs_t x);
    vec_t v;
    v.name = nm; v.ncyc = n; v.start = st; v.abort = ab;
    v.early = e; v.late = l; v.oor = o; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, obs_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (load,clear,move,dir,busy,done,err,tap[7:0])",
               nm, obs, exp);
    end
  endtask

  task automatic check_int(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    train_start = v.start;
    train_abort = v.abort;
    eye_monitor_early = v.early;
    eye_monitor_late = v.late;
    delay_line_out_of_range = v.oor;
    repeat (v.ncyc) @(posedge fab_clk);
    #1;
    check(v.name, v.exp);
  endtask

  // Strobe hygiene: never two at once, never wider than one cycle
  always @(negedge fab_clk) begin
    if (arst_n) begin
      n_checks++;
      if ((int'(delay_line_load) + int'(eye_monitor_clear_flags) + int'(delay_line_move)) > 1
          || (delay_line_load && prev_load) || (eye_monitor_clear_flags && prev_clear)
          || (delay_line_move && prev_move)) begin
        n_fail++;
        $display("FAIL strobe_rule at %0t: load=%0b clear=%0b move=%0b prev=%0b%0b%0b, required one-hot single-cycle",
                 $time, delay_line_load, eye_monitor_clear_flags, delay_line_move,
                 prev_load, prev_clear, prev_move);
      end
      if (delay_line_move) moves_seen++;
      prev_load = delay_line_load;
      prev_clear = eye_monitor_clear_flags;
      prev_move = delay_line_move;
    end else begin
      prev_load = 1'b0;
      prev_clear = 1'b0;
      prev_move = 1'b0;
    end
  end

  initial begin
    //   name                 ncyc st ab e  l  o   load clr mv dir busy done err tap
    add("reset",               0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    add("bal_load",            1, 1, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 0, 0));
    add("bal_clear",           1, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 0, 0));
    add("bal_settle",          1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0));
    add("bal_sample1",         8, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0));
    add("bal_clear2",          1, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 0, 0));
    add("bal_sample4",        29, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0));
    add("bal_done",            1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    add("bal_halt",            5, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    add("early_load",          1, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 0, 0, 0));
    add("early_move1",        11, 0, 0, 1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));
    add("early_tap1",          1, 0, 0, 1, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 1));
    add("early_move3",        21, 0, 0, 1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 2));
    add("early_tap3",          1, 0, 0, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 3));
    add("early_last_sample",  39, 0, 0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 0, 3));
    add("early_done",          1, 0, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 0, 3));
    add("late_load",           1, 1, 0, 0, 1, 0, mk(1, 0, 0, 1, 1, 0, 0, 3));
    add("late_sample",        10, 0, 0, 0, 1, 0, mk(0, 0, 0, 1, 1, 0, 0, 0));
    add("late_err",            1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0));
    add("late_err_hold",       5, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0));
    add("abort_load",          1, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 0, 0, 0));
    add("abort_tap1",         12, 0, 0, 1, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 1));
    add("abort_settle",        3, 0, 0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 0, 1));
    add("abort_idle",          1, 1, 1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 1));
    add("abort_start_ignored", 3, 0, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 1));
    add("oor_load",            1, 1, 0, 1, 0, 1, mk(1, 0, 0, 1, 1, 0, 0, 1));
    add("oor_err",            11, 0, 0, 1, 0, 1, mk(0, 0, 0, 1, 0, 0, 1, 0));

    repeat (3) @(posedge fab_clk);
    @(negedge fab_clk);
    arst_n = 1'b1;
    @(posedge fab_clk);
    #1;
    moves_seen = 0;
    foreach (vecs[i]) apply(vecs[i]);
    check_int("table_move_pulses", moves_seen, 4);

    // Alternating EARLY/LATE: 256 moves accepted, the 257th request exhausts the budget
    delay_line_out_of_range = 1'b0;
    moves_seen = 0;
    train_start = 1'b1;
    eye_monitor_early = 1'b1;
    eye_monitor_late = 1'b0;
    @(posedge fab_clk);
    #1;
    train_start = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      repeat (11) @(posedge fab_clk);
      #1;
      eye_monitor_early = (k % 2) == 0;
      eye_monitor_late = (k % 2) != 0;
    end
    repeat (10) @(posedge fab_clk);
    #1;
    check("budget_last_sample", mk(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge fab_clk);
    #1;
    check("budget_err", mk(0, 0, 0, 1, 0, 0, 1, 0));
    check_int("budget_move_pulses", moves_seen, 256);

    // Asynchronous reset in the middle of a MOVE pulse, then a clean retrain
    train_start = 1'b1;
    eye_monitor_early = 1'b1;
    eye_monitor_late = 1'b0;
    @(posedge fab_clk);
    #1;
    train_start = 1'b0;
    repeat (11) @(posedge fab_clk);
    #1;
    check("rst_in_move", mk(0, 0, 1, 1, 1, 0, 0, 0));
    #2;
    arst_n = 1'b0;
    #1;
    check("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0));
    eye_monitor_early = 1'b0;
    @(negedge fab_clk);
    arst_n = 1'b1;
    @(posedge fab_clk);
    #1;
    moves_seen = 0;
    train_start = 1'b1;
    @(posedge fab_clk);
    #1;
    check("rst_retrain_load", mk(1, 0, 0, 0, 1, 0, 0, 0));
    train_start = 1'b0;
    repeat (41) @(posedge fab_clk);
    #1;
    check("rst_retrain_done", mk(0, 0, 0, 0, 0, 1, 0, 0));
    check_int("rst_retrain_moves", moves_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
